// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the mul_arbiter block.
package mul_arb_pkg;
  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/multiplier.sv
// Combinational radix-4 Booth multiplier, signed OP_W x OP_W -> RES_W.
module multiplier
  import mul_arb_pkg::*;
(
  input  logic signed [OP_W-1:0]  a_i,
  input  logic signed [OP_W-1:0]  b_i,
  output logic signed [RES_W-1:0] p_o
);

  logic signed [RES_W-1:0] a_ext;
  logic        [OP_W:0]    b_ext;
  logic        [2:0]       trip;
  logic signed [RES_W-1:0] pp;

  assign a_ext = RES_W'(a_i);
  assign b_ext = {b_i, 1'b0};

  // Sum of OP_W/2 Booth-recoded partial products, each shifted by two bits.
  always_comb begin
    p_o  = '0;
    trip = '0;
    pp   = '0;
    for (int i = 0; i < OP_W / 2; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      p_o = p_o + (pp <<< (2 * i));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Request arbiter: one-hot grant plus encoded index.
// MUL_ARB_RR_EN defined: round-robin search from an internal pointer that
// advances past each accepted grant. Undefined: fixed priority, lowest wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
`ifdef MUL_ARB_RR_EN
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv_i,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] gid_o
);

`ifdef MUL_ARB_RR_EN
  logic [ID_W-1:0] ptr_q;
  logic            found;
  int              idx;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_o = '0;
    gid_o   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        gid_o        = ID_W'(idx);
      end
    end
  end

  // Pointer moves to the slot after the winner once the grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (adv_i)
      ptr_q <= (int'(gid_o) == NREQ - 1) ? '0 : gid_o + 1'b1;
  end
`else
  // Lowest set index wins; scan downward so the last hit is the lowest.
  always_comb begin
    grant_o = '0;
    gid_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
        gid_o      = ID_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/mul_arbiter.sv
// Shares one Booth multiplier among NREQ valid/ready requesters.
// IDLE grants and latches operands, CALC registers the product, RESP holds
// the result until the owner accepts it. Optional macro: MUL_ARB_RR_EN
// selects round-robin arbitration (default fixed priority).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [RES_W-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  state_t                  state_q, state_d;
  logic [NREQ-1:0]         grant;
  logic [ID_W-1:0]         gid;
  logic                    any_req;
  logic                    accept;
  logic signed [OP_W-1:0]  op_a_q, op_b_q;
  logic [ID_W-1:0]         id_q;
  logic [ID_W-1:0]         resp_id_q;
  logic signed [RES_W-1:0] prod;
  logic [RES_W-1:0]        res_q;

  assign any_req = |req_valid;
  assign accept  = (state_q == IDLE) && any_req;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
`ifdef MUL_ARB_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (accept),
`endif
    .req_i  (req_valid),
    .grant_o(grant),
    .gid_o  (gid)
  );

  multiplier u_mul (
    .a_i(op_a_q),
    .b_i(op_b_q),
    .p_o(prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: single-cycle CALC, RESP waits for the owner's resp_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (resp_ready[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; grants only in IDLE and never while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE:    if (rst_n) req_ready = grant;
      RESP:    resp_valid = NREQ'(1) << id_q;
      default: ;
    endcase
  end

  // Operand capture on grant; result and owner registered out of CALC so
  // they hold after the handshake until the next product is formed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      res_q     <= '0;
      resp_id_q <= '0;
    end else begin
      if (accept) begin
        op_a_q <= req_a[int'(gid)*OP_W +: OP_W];
        op_b_q <= req_b[int'(gid)*OP_W +: OP_W];
        id_q   <= gid;
      end
      if (state_q == CALC) begin
        res_q     <= prod;
        resp_id_q <= id_q;
      end
    end
  end

  assign resp_data = res_q;
  assign resp_id   = resp_id_q;

endmodule
